timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_pkg.sv | 19 +
 rtl/timer_ctrl_count_core.sv | 25 ++
 rtl/timer_ctrl.sv | 109 ++++++++++
 tb/tb_timer_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared types and defaults for the timer_ctrl block.
// State and mode enums are used by both the controller and the bench.
package timer_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/timer_ctrl_count_core.sv
// Plain up-counter used by timer_ctrl.
// When clr and en are both high, clr wins.
module count_core
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable one-shot / periodic timer.
// Holds the FSM, the configuration registers and the tick/done decode.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_mode,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] limit_q;
  mode_e            mode_q;
  logic             cfg_take;
  logic             start_ok;
  logic             at_limit;
  logic             cnt_clr;
  logic             cnt_en;

  assign cfg_take = cfg_valid && cfg_ready;
  // A configuration handshake in the same cycle always beats a start.
  assign start_ok = start && !cfg_valid && (limit_q != '0);
  assign at_limit = (out == limit_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      limit_q <= '1;
      mode_q  <= ONE_SHOT;
    end else if (cfg_take) begin
      limit_q <= cfg_limit;
      mode_q  <= mode_e'(cfg_mode);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = RUN;
      end
      RUN: begin
        if (stop)                                state_nxt = IDLE;
        else if (pause)                          state_nxt = HOLD;
        else if (at_limit && mode_q == ONE_SHOT) state_nxt = DONE;
      end
      HOLD: begin
        if (stop)        state_nxt = IDLE;
        else if (!pause) state_nxt = RUN;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The counter only advances in RUN below the limit; every exit to IDLE
  // and every periodic wrap clears it.
  always_comb begin
    cfg_ready = (state == IDLE);
    busy      = (state != IDLE);
    tick      = (state == RUN) && at_limit && !stop && !pause;
    done      = (state == DONE);
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: cnt_clr = start_ok;
      RUN: begin
        cnt_clr = stop || (tick && mode_q == PERIODIC);
        cnt_en  = !stop && !pause && !at_limit;
      end
      HOLD: cnt_clr = stop;
      DONE: cnt_clr = 1'b1;
      default: cnt_clr = 1'b1;
    endcase
  end

  count_core #(
    .WIDTH(WIDTH)
  ) u_count_core (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .value(out)
  );

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_timer_ctrl;

  localparam int W = 7;
  localparam int LIM_MAX = (1 << W) - 1;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_HOLD = 2;
  localparam int P_DONE = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [W-1:0] cfg_limit = '0;
  logic         cfg_mode = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] out;
  logic         busy;
  logic         tick;
  logic         done;

  int num_compared = 0;
  int num_mismatched = 0;

  int m_phase;
  int m_count;
  int m_limit;
  int m_periodic;

  timer_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_limit(cfg_limit),
    .cfg_mode (cfg_mode),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .out      (out),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_phase    = P_IDLE;
    m_count    = 0;
    m_limit    = LIM_MAX;
    m_periodic = 0;
  endtask

  // Expected tick for the current model state and the inputs now applied.
  function automatic int modelTick();
    return (m_phase == P_RUN && m_count == m_limit && !stop && !pause) ? 1 : 0;
  endfunction

  task automatic modelStep();
    case (m_phase)
      P_IDLE: begin
        if (cfg_valid) begin
          m_limit    = int'(cfg_limit);
          m_periodic = int'(cfg_mode);
        end else if (start && m_limit != 0) begin
          m_phase = P_RUN;
          m_count = 0;
        end
      end
      P_RUN: begin
        if (stop) begin
          m_phase = P_IDLE;
          m_count = 0;
        end else if (pause) begin
          m_phase = P_HOLD;
        end else if (m_count == m_limit) begin
          if (m_periodic != 0) m_count = 0;
          else m_phase = P_DONE;
        end else begin
          m_count = m_count + 1;
        end
      end
      P_HOLD: begin
        if (stop) begin
          m_phase = P_IDLE;
          m_count = 0;
        end else if (!pause) begin
          m_phase = P_RUN;
        end
      end
      default: begin
        m_phase = P_IDLE;
        m_count = 0;
      end
    endcase
  endtask

  task automatic checkModel();
    checkOutput("out",       int'(out),       m_count);
    checkOutput("busy",      int'(busy),      (m_phase != P_IDLE) ? 1 : 0);
    checkOutput("tick",      int'(tick),      modelTick());
    checkOutput("done",      int'(done),      (m_phase == P_DONE) ? 1 : 0);
    checkOutput("cfg_ready", int'(cfg_ready), (m_phase == P_IDLE) ? 1 : 0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic cv, input int cl, input logic cm,
                               input logic st, input logic sp, input logic pa);
    cfg_valid = cv;
    cfg_limit = W'(cl);
    cfg_mode  = cm;
    start     = st;
    stop      = sp;
    pause     = pa;
    #1;
    checkModel();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int exp_out_035[6]  = '{0, 1, 2, 3, 3, 0};
  int exp_done_035[6] = '{0, 0, 0, 0, 1, 0};
  int exp_busy_035[6] = '{1, 1, 1, 1, 1, 0};

  initial begin
    modelReset();
    #2;
    checkOutput("rst_out",       int'(out),       0);
    checkOutput("rst_busy",      int'(busy),      0);
    checkOutput("rst_tick",      int'(tick),      0);
    checkOutput("rst_done",      int'(done),      0);
    checkOutput("rst_cfg_ready", int'(cfg_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] periodic limit 5");
    applyStimulus(1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      checkOutput("p5_out",  int'(out),  i % 6);
      checkOutput("p5_tick", int'(tick), (i % 6 == 5) ? 1 : 0);
      checkOutput("p5_busy", int'(busy), 1);
      idleCycles(1);
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] one-shot limit 3");
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("os3_out",  int'(out),  exp_out_035[i]);
      checkOutput("os3_done", int'(done), exp_done_035[i]);
      checkOutput("os3_busy", int'(busy), exp_busy_035[i]);
      checkOutput("os3_tick", int'(tick), (i == 3) ? 1 : 0);
      idleCycles(1);
    end

    $display("[TB] pause at 4, limit 10");
    applyStimulus(1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("pause_out",  int'(out),  4);
      checkOutput("pause_busy", int'(busy), 1);
    end
    idleCycles(2);
    checkOutput("resume_out", int'(out), 5);
    idleCycles(1);
    checkOutput("resume_out", int'(out), 6);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] stop+pause at 7, limit 20");
    applyStimulus(1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(7);
    checkOutput("pre_stop_out", int'(out), 7);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("stop_out",  int'(out),  0);
    checkOutput("stop_busy", int'(busy), 0);
    checkOutput("stop_done", int'(done), 0);

    $display("[TB] limit 0 ignores start");
    applyStimulus(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lim0_busy_a", int'(busy), 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lim0_busy_b", int'(busy), 0);
    idleCycles(2);

    $display("[TB] async reset mid-run, limit 127");
    applyStimulus(1'b1, 127, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(50);
    checkOutput("pre_rst_out", int'(out), 50);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_out",       int'(out),       0);
    checkOutput("arst_busy",      int'(busy),      0);
    checkOutput("arst_tick",      int'(tick),      0);
    checkOutput("arst_done",      int'(done),      0);
    checkOutput("arst_cfg_ready", int'(cfg_ready), 1);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(127);
    checkOutput("rst_limit_out",  int'(out),  127);
    checkOutput("rst_limit_tick", int'(tick), 1);
    idleCycles(1);
    checkOutput("rst_mode_done", int'(done), 1);
    idleCycles(1);

    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++) begin
      logic cv, cm, st, sp, pa;
      int   cl;
      cv = ($urandom_range(7) == 0);
      cl = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(12));
      cm = 1'($urandom_range(1));
      st = ($urandom_range(2) == 0);
      sp = ($urandom_range(24) == 0);
      pa = ($urandom_range(9) == 0);
      applyStimulus(cv, cl, cm, st, sp, pa);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
